// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses sync + N_BYTES payload (+ checksum) from a UART ready/ack stream into image RAM.
// Optional trailing checksum byte enabled by defining UART_FRAME_LOADER_CHECKSUM_EN.
`default_nettype none

module uart_frame_loader #(
    parameter int          N_BYTES   = 784,
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 500000,
    parameter int          TO_W      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_ready_i,
    output logic              rx_ack_o,
    input  logic              rx_error_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERR     = 3'd4;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd2;
`endif

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [ADDR_W-1:0] byte_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              ack_wait;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic in_frame;
    logic timed_out;
    logic last_byte;
    logic take;
    logic ack_n;
    logic wr_n;
    logic done_n;
    logic err_n;
    logic busy_n;

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    assign in_frame = (state == S_PAYLOAD) || (state == S_CHECK);
`else
    assign in_frame = (state == S_PAYLOAD);
`endif
    assign timed_out = in_frame && (to_cnt == TO_W'(TIMEOUT - 1));
    assign last_byte = (byte_cnt == ADDR_W'(N_BYTES - 1));
    // Error and timeout take priority over a byte arriving in the same cycle.
    assign take = rx_ready_i && !ack_wait && !rx_error_i &&
                  ((state == S_HUNT) || (in_frame && !timed_out));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_HUNT;
            byte_cnt     <= '0;
            to_cnt       <= '0;
            ack_wait     <= 1'b0;
            rx_ack_o     <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            busy_o       <= 1'b0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state        <= state_n;
            rx_ack_o     <= ack_n;
            wr_en_o      <= wr_n;
            frame_done_o <= done_n;
            frame_err_o  <= err_n;
            busy_o       <= busy_n;

            if (take) begin
                ack_wait <= 1'b1;
            end else if (!rx_ready_i) begin
                ack_wait <= 1'b0;
            end

            if (!in_frame || take) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state == S_HUNT) begin
                byte_cnt <= '0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (wr_n) begin
                byte_cnt  <= byte_cnt + 1'b1;
                wr_addr_o <= byte_cnt;
                wr_data_o <= rx_data_i;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                csum      <= csum + rx_data_i;
`endif
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_HUNT: begin
                if (take && (rx_data_i == SYNC_BYTE)) begin
                    state_n = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rx_error_i || timed_out) begin
                    state_n = S_ERR;
                end else if (take && last_byte) begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                    state_n = S_CHECK;
`else
                    state_n = S_DONE;
`endif
                end
            end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_error_i || timed_out) begin
                    state_n = S_ERR;
                end else if (take) begin
                    state_n = (rx_data_i == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_n = S_HUNT;
            S_ERR:   state_n = S_HUNT;
            default: state_n = S_HUNT;
        endcase
    end

    always_comb begin
        ack_n  = take;
        wr_n   = take && (state == S_PAYLOAD);
        done_n = (state == S_DONE);
        err_n  = (state == S_ERR);
        busy_n = (state_n != S_HUNT);
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: cycle model plus directed frame scenarios.
`default_nettype none

module tb_uart_frame_loader;

    localparam int         N       = 4;
    localparam int         AW      = 3;
    localparam int         TMO     = 200;
    localparam logic [7:0] SYNC    = 8'hA5;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    localparam bit         CHK     = 1'b1;
`else
    localparam bit         CHK     = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic          rx_error = 1'b0;
    logic          rx_ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          frame_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    uart_frame_loader #(
        .N_BYTES(N), .ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT(TMO), .TO_W(8)
    ) dut (
        .clk(clk), .reset(reset), .rx_data_i(rx_data), .rx_ready_i(rx_ready),
        .rx_ack_o(rx_ack), .rx_error_i(rx_error), .wr_en_o(wr_en),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .frame_done_o(frame_done),
        .frame_err_o(frame_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a frame is a queue of received payload bytes.
    bit         started = 1'b0;
    bit         m_active = 1'b0;
    bit         m_wait = 1'b0;
    bit         m_took;
    int         m_hold = 0;
    int         m_idle = 0;
    logic [7:0] m_q[$];
    logic       e_ack = 0, e_wr = 0, e_done = 0, e_err = 0, e_busy = 0;
    logic [AW-1:0] e_addr = '0;
    logic [7:0]    e_data = '0;

    function automatic logic [7:0] qsum(input logic [7:0] q[$]);
        logic [7:0] s = 8'h00;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        e_ack = 0; e_wr = 0; e_done = 0; e_err = 0;
        m_took = 1'b0;
        if (!reset) begin
            m_active = 0; m_wait = 0; m_hold = 0; m_idle = 0; m_q.delete();
            e_addr = '0; e_data = '0; e_busy = 0;
        end else begin
            if (m_hold != 0) begin
                e_done = (m_hold == 1);
                e_err  = (m_hold == 2);
                m_hold = 0;
            end else if (m_active && (rx_error || m_idle == TMO - 1)) begin
                m_hold = 2;
                m_active = 0;
            end else if (rx_ready && !m_wait && !rx_error) begin
                m_took = 1'b1;
                e_ack = 1;
                if (!m_active) begin
                    if (rx_data == SYNC) begin
                        m_active = 1; m_q.delete(); m_idle = 0;
                    end
                end else if (m_q.size() < N) begin
                    e_wr = 1; e_addr = AW'(m_q.size()); e_data = rx_data;
                    m_q.push_back(rx_data);
                    m_idle = 0;
                    if (m_q.size() == N && !CHK) begin
                        m_hold = 1; m_active = 0;
                    end
                end else begin
                    m_hold = (qsum(m_q) == rx_data) ? 1 : 2;
                    m_active = 0;
                end
            end else if (m_active) begin
                m_idle++;
            end
            if (m_took) m_wait = 1;
            else if (!rx_ready) m_wait = 0;
            e_busy = m_active || (m_hold != 0);
        end
    end

    // Compare against model every cycle, plus event logging for directed checks.
    int cyc = 0;
    int ack_cnt = 0, done_cnt = 0, err_cnt = 0, last_ack_cyc = 0, done_cyc = 0;
    int wa_log[$];
    int wd_log[$];

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            chk("ack",   rx_ack,     e_ack);
            chk("wr_en", wr_en,      e_wr);
            chk("addr",  wr_addr,    e_addr);
            chk("data",  wr_data,    e_data);
            chk("done",  frame_done, e_done);
            chk("err",   frame_err,  e_err);
            chk("busy",  busy,       e_busy);
        end
        if (rx_ack)     begin ack_cnt++; last_ack_cyc = cyc; end
        if (wr_en)      begin wa_log.push_back(int'(wr_addr)); wd_log.push_back(int'(wr_data)); end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (frame_err)  err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        rx_data = b;
        rx_ready = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rx_ack) got = 1'b1;
        end
        if (!got) chk("ack_wait_timeout", 0, 1);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_list(input logic [7:0] bl[$]);
        foreach (bl[i]) send_byte(bl[i]);
    endtask

    task automatic clear_logs();
        ack_cnt = 0; done_cnt = 0; err_cnt = 0;
        wa_log.delete(); wd_log.delete();
    endtask

    initial begin
        logic [7:0] fr[$];
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", rx_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr_en, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame
        clear_logs();
        fr = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        if (CHK) fr.push_back(8'h0A);
        send_list(fr);
        repeat (4) @(negedge clk);
        chk("s1_writes", wa_log.size(), 4);
        for (int i = 0; i < 4 && i < wa_log.size(); i++) begin
            chk("s1_addr", wa_log[i], i);
            chk("s1_data", wd_log[i], i + 1);
        end
        chk("s1_done", done_cnt, 1);
        chk("s1_err", err_cnt, 0);
        chk("s1_done_lat", done_cyc - last_ack_cyc, 1);
        chk("s1_busy", busy, 0);

        // Stray byte in HUNT is discarded
        clear_logs();
        send_byte(8'h0A);
        repeat (3) @(negedge clk);
        chk("stray_ack", ack_cnt, 1);
        chk("stray_wr", wa_log.size(), 0);
        chk("stray_err", err_cnt + done_cnt, 0);

        // Junk before sync, bad checksum (correct would be A0)
        clear_logs();
        send_list('{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00});
        repeat (4) @(negedge clk);
        chk("s2_acks", ack_cnt, 8);
        chk("s2_writes", wa_log.size(), 4);
        if (wa_log.size() > 0) chk("s2_first_data", wd_log[0], 8'h10);
        chk("s2_err", err_cnt, CHK ? 1 : 0);
        chk("s2_done", done_cnt, CHK ? 0 : 1);
        chk("s2_busy", busy, 0);

        // Ready held high: single consumption
        clear_logs();
        rx_data = 8'hA5;
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("s3_acks", ack_cnt, 1);
        chk("s3_busy", busy, 1);
        chk("s3_writes", wa_log.size(), 0);
        fr = '{8'h00, 8'h00, 8'h00, 8'h00};
        if (CHK) fr.push_back(8'h00);
        send_list(fr);
        repeat (3) @(negedge clk);
        chk("s3_done", done_cnt, 1);

        // Timeout, then recovery
        clear_logs();
        send_list('{8'hA5, 8'h11, 8'h22});
        base = cyc;
        for (int i = 0; i < 400 && err_cnt == 0; i++) @(negedge clk);
        chk("s4_err", err_cnt, 1);
        chk("s4_idle_bound", (cyc - base) < 300, 1);
        chk("s4_busy", busy, 0);
        fr = '{8'hA5, 8'h01, 8'h01, 8'h01, 8'h01};
        if (CHK) fr.push_back(8'h04);
        send_list(fr);
        repeat (3) @(negedge clk);
        chk("s4_done", done_cnt, 1);
        chk("s4_err_after", err_cnt, 1);

        // UART error mid-frame
        clear_logs();
        send_list('{8'hA5, 8'h33, 8'h44});
        rx_data = 8'h55;
        rx_ready = 1'b1;
        rx_error = 1'b1;
        repeat (6) @(negedge clk);
        chk("s5_acks", ack_cnt, 3);
        chk("s5_err", err_cnt, 1);
        chk("s5_busy", busy, 0);
        rx_error = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame
        clear_logs();
        send_list('{8'hA5, 8'h66});
        chk("s6_busy_before", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("s6_busy", busy, 0);
        chk("s6_addr", wr_addr, 0);
        chk("s6_data", wr_data, 0);
        chk("s6_wr", wr_en, 0);
        chk("s6_err", err_cnt, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        fr = '{8'hA5, 8'h05, 8'h06, 8'h07, 8'h08};
        if (CHK) fr.push_back(8'h1A);
        send_list(fr);
        repeat (3) @(negedge clk);
        chk("s6_done", done_cnt, 1);
        chk("s6_err_after", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
